// File: rtl/morse_pkg.sv
// Shared definitions for the Morse playback engine: symbol codes, phase
// lengths in units, FSM encoding and the built-in word table.
package morse_pkg;

  localparam logic [1:0] SYM_DOT  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_GAP  = 2'b11;
  localparam logic [1:0] SYM_END  = 2'b10;

  // Phase lengths expressed in Morse units
  localparam int MULT_DOT  = 1;
  localparam int MULT_DASH = 3;
  localparam int MULT_GAP  = 2;
  localparam int MULT_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ON      = 3'd2,
    ST_OFF     = 3'd3,
    ST_GAP     = 3'd4,
    ST_WORDGAP = 3'd5
  } state_t;

  // Built-in words, symbol 0 in the least significant bits
  localparam logic [3:0]  WORD_E   = {SYM_END, SYM_DOT};
  localparam logic [3:0]  WORD_T   = {SYM_END, SYM_DASH};
  localparam logic [23:0] WORD_SOS = {SYM_END, SYM_DOT, SYM_DOT, SYM_DOT,
                                      SYM_GAP, SYM_DASH, SYM_DASH, SYM_DASH,
                                      SYM_GAP, SYM_DOT, SYM_DOT, SYM_DOT};
  localparam logic [5:0]  WORD_A   = {SYM_END, SYM_DASH, SYM_DOT};

  // Symbol of the built-in table; every unlisted slot reads as END
  function automatic logic [1:0] default_sym(input logic [31:0] sel,
                                             input logic [31:0] idx);
    logic [1:0] s;
    s = SYM_END;
    case (sel)
      32'd0:   if (idx < 32'd2)  s = WORD_E[idx*32'd2 +: 2];   else s = SYM_END;
      32'd1:   if (idx < 32'd2)  s = WORD_T[idx*32'd2 +: 2];   else s = SYM_END;
      32'd2:   if (idx < 32'd12) s = WORD_SOS[idx*32'd2 +: 2]; else s = SYM_END;
      32'd3:   if (idx < 32'd3)  s = WORD_A[idx*32'd2 +: 2];   else s = SYM_END;
      default: s = SYM_END;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/morse_seq_player_if.sv
// Control/status bundle between the puzzle controller (master) and the
// Morse playback engine (slave).
interface morse_seq_player_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] data;
  logic              set;
  logic              loop;
  logic              abort;
  logic              morse_led;
  logic              busy;
  logic              done;

  modport master (output data, set, loop, abort,
                  input  morse_led, busy, done);
  modport slave  (input  data, set, loop, abort,
                  output morse_led, busy, done);
endinterface

// File: rtl/morse_word_rom.sv
// Combinational word table: (word select, symbol index) -> 2-bit symbol.
// An override table can replace the built-in words for other products.
module morse_word_rom
  import morse_pkg::*;
#(
  parameter int SEL_W     = 2,
  parameter int SEQ_DEPTH = 16,
  parameter int IDX_W     = 4,
  parameter bit USE_TABLE = 1'b0,
  parameter logic [2*SEQ_DEPTH*(2**SEL_W)-1:0] TABLE = '0
) (
  input  logic [SEL_W-1:0] i_sel,
  input  logic [IDX_W-1:0] i_idx,
  output logic [1:0]       o_sym
);

  // Table lookup; override layout is word-major, two bits per symbol
  always_comb begin
    o_sym = SYM_END;
    if (USE_TABLE) begin
      o_sym = TABLE[(32'(i_sel) * 32'(SEQ_DEPTH) + 32'(i_idx)) * 32'd2 +: 2];
    end else begin
      o_sym = default_sym(32'(i_sel), 32'(i_idx));
    end
  end

endmodule

// File: rtl/morse_seq_player.sv
// Morse playback engine: plays one stored word on the LED with unit-based
// timing, optionally looping with a word gap, with abort and done/busy status.
module morse_seq_player
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 10000,
  parameter int SEL_W       = 2,
  parameter int SEQ_DEPTH   = 16,
  parameter int DATA_W      = 16,
  parameter bit USE_TABLE   = 1'b0,
  parameter logic [2*SEQ_DEPTH*(2**SEL_W)-1:0] TABLE = '0
) (
  input  logic               clk,
  input  logic               reset,
  morse_seq_player_if.slave  bus
);

  localparam int TMR_W = $clog2(4*UNIT_CYCLES+1);
  localparam int IDX_W = $clog2(SEQ_DEPTH);

  localparam logic [TMR_W-1:0] T_DOT  = TMR_W'(UNIT_CYCLES*MULT_DOT);
  localparam logic [TMR_W-1:0] T_DASH = TMR_W'(UNIT_CYCLES*MULT_DASH);
  localparam logic [TMR_W-1:0] T_GAP  = TMR_W'(UNIT_CYCLES*MULT_GAP);
  localparam logic [TMR_W-1:0] T_WORD = TMR_W'(UNIT_CYCLES*MULT_WORD);
  localparam logic [TMR_W-1:0] T_ONE  = TMR_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_DEPTH-1);

  state_t           r_state, w_state;
  logic [TMR_W-1:0] r_timer, w_timer;
  logic [IDX_W-1:0] r_idx,   w_idx;
  logic             r_last,  w_last;   // last slot played: next fetch is END
  logic [SEL_W-1:0] r_sel,   w_sel;
  logic             r_loop,  w_loop;
  logic             r_led, r_busy, r_done;
  logic             w_done;
  logic             w_expired;
  logic [1:0]       w_sym;

  morse_word_rom #(
    .SEL_W     (SEL_W),
    .SEQ_DEPTH (SEQ_DEPTH),
    .IDX_W     (IDX_W),
    .USE_TABLE (USE_TABLE),
    .TABLE     (TABLE)
  ) u_rom (
    .i_sel (r_sel),
    .i_idx (r_idx),
    .o_sym (w_sym)
  );

  // Next-state logic: abort wins over expiry and END decode
  always_comb begin
    w_state   = r_state;
    w_timer   = r_timer;
    w_idx     = r_idx;
    w_last    = r_last;
    w_sel     = r_sel;
    w_loop    = r_loop;
    w_done    = 1'b0;
    w_expired = (r_timer == T_ONE);
    if ((r_state != ST_IDLE) && bus.abort) begin
      w_state = ST_IDLE;
      w_timer = '0;
      w_idx   = '0;
      w_last  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.set) begin
            w_state = ST_FETCH;
            w_sel   = bus.data[SEL_W-1:0];
            w_loop  = bus.loop;
            w_idx   = '0;
            w_last  = 1'b0;
          end else begin
            w_state = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (r_last || (w_sym == SYM_END)) begin
            if (r_loop) begin
              w_state = ST_WORDGAP;
              w_timer = T_WORD;
            end else begin
              w_state = ST_IDLE;
              w_done  = 1'b1;
              w_timer = '0;
              w_idx   = '0;
              w_last  = 1'b0;
            end
          end else if (w_sym == SYM_GAP) begin
            w_state = ST_GAP;
            w_timer = T_GAP;
          end else if (w_sym == SYM_DASH) begin
            w_state = ST_ON;
            w_timer = T_DASH;
          end else begin
            w_state = ST_ON;
            w_timer = T_DOT;
          end
        end
        ST_ON: begin
          if (w_expired) begin
            w_state = ST_OFF;
            w_timer = T_DOT;
          end else begin
            w_timer = r_timer - T_ONE;
          end
        end
        ST_OFF, ST_GAP: begin
          if (w_expired) begin
            w_state = ST_FETCH;
            if (r_idx == IDX_LAST) begin
              w_last = 1'b1;
            end else begin
              w_idx = r_idx + IDX_W'(1);
            end
          end else begin
            w_timer = r_timer - T_ONE;
          end
        end
        ST_WORDGAP: begin
          if (w_expired) begin
            w_state = ST_FETCH;
            w_idx   = '0;
            w_last  = 1'b0;
          end else begin
            w_timer = r_timer - T_ONE;
          end
        end
        default: begin
          w_state = ST_IDLE;
          w_timer = '0;
          w_idx   = '0;
          w_last  = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_sel   <= '0;
      r_loop  <= 1'b0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_timer <= w_timer;
      r_idx   <= w_idx;
      r_last  <= w_last;
      r_sel   <= w_sel;
      r_loop  <= w_loop;
      r_led   <= (w_state == ST_ON);
      r_busy  <= (w_state != ST_IDLE);
      r_done  <= w_done;
    end
  end

  assign bus.morse_led = r_led;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_morse_seq_player.sv
// Directed bench for morse_seq_player: default table at UNIT_CYCLES=4 plus a
// UNIT_CYCLES=1 / SEQ_DEPTH=2 instance whose word has no END symbol.
module tb_morse_seq_player;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  logic cap_led  [0:255];
  logic cap_busy [0:255];
  logic cap_done [0:255];

  morse_seq_player_if #(.DATA_W(16)) bus1 ();
  morse_seq_player_if #(.DATA_W(16)) bus2 ();

  morse_seq_player #(
    .UNIT_CYCLES (4),
    .SEL_W       (2),
    .SEQ_DEPTH   (16),
    .DATA_W      (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // word0 = {dash, dot}, no END; other words all dots
  morse_seq_player #(
    .UNIT_CYCLES (1),
    .SEL_W       (2),
    .SEQ_DEPTH   (2),
    .DATA_W      (16),
    .USE_TABLE   (1'b1),
    .TABLE       (16'h0001)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      n_pass = n_pass + 1;
    end
  endtask

  // Request a start on dut; returns just after the accepting edge (edge 0)
  task automatic start1(input int sel, input logic lp, input logic hold);
    @(negedge clk);
    bus1.data = 16'(sel);
    bus1.loop = lp;
    bus1.set  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus1.set = 1'b0;
  endtask

  // cap_*[k] holds dut outputs after edge k
  task automatic capture1(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cap_led[k]  = bus1.morse_led;
      cap_busy[k] = bus1.busy;
      cap_done[k] = bus1.done;
    end
  endtask

  task automatic capture2(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cap_led[k]  = bus2.morse_led;
      cap_busy[k] = bus2.busy;
      cap_done[k] = bus2.done;
    end
  endtask

  function automatic int count_led(input int lo, input int hi);
    int c;
    c = 0;
    for (int k = lo; k <= hi; k++) if (cap_led[k]) c++;
    return c;
  endfunction

  function automatic int count_done(input int lo, input int hi);
    int c;
    c = 0;
    for (int k = lo; k <= hi; k++) if (cap_done[k]) c++;
    return c;
  endfunction

  initial begin
    int   pl[$];
    int   gl[$];
    int   run;
    logic prev;
    logic seen;
    int   exp_p[13];
    int   exp_g[13];

    n_pass  = 0;
    n_total = 0;
    exp_p = '{4, 4, 4, 12, 12, 12, 4, 4, 4, 4, 4, 4, 12};
    exp_g = '{5, 5, 14, 5, 5, 14, 5, 5, 22, 5, 5, 14, 5};

    reset = 1'b0;
    bus1.data = 16'd0; bus1.set = 1'b0; bus1.loop = 1'b0; bus1.abort = 1'b0;
    bus2.data = 16'd0; bus2.set = 1'b0; bus2.loop = 1'b0; bus2.abort = 1'b0;
    #1;
    chk("rst_led",  32'(bus1.morse_led), 32'd0);
    chk("rst_busy", 32'(bus1.busy),      32'd0);
    chk("rst_done", 32'(bus1.done),      32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Word 0 "E": one dot
    start1(0, 1'b0, 1'b0);
    capture1(14);
    chk("e_led0",   32'(cap_led[0]),  32'd0);
    chk("e_led1",   32'(cap_led[1]),  32'd1);
    chk("e_led4",   32'(cap_led[4]),  32'd1);
    chk("e_led5",   32'(cap_led[5]),  32'd0);
    chk("e_on_cnt", 32'(count_led(0, 13)), 32'd4);
    chk("e_busy0",  32'(cap_busy[0]), 32'd1);
    chk("e_busy9",  32'(cap_busy[9]), 32'd1);
    chk("e_busy10", 32'(cap_busy[10]), 32'd0);
    chk("e_done9",  32'(cap_done[9]), 32'd0);
    chk("e_done10", 32'(cap_done[10]), 32'd1);
    chk("e_done_n", 32'(count_done(0, 13)), 32'd1);

    // Word 1 "T": one dash
    start1(1, 1'b0, 1'b0);
    capture1(22);
    chk("t_led1",   32'(cap_led[1]),  32'd1);
    chk("t_led12",  32'(cap_led[12]), 32'd1);
    chk("t_led13",  32'(cap_led[13]), 32'd0);
    chk("t_on_cnt", 32'(count_led(0, 21)), 32'd12);
    chk("t_busy17", 32'(cap_busy[17]), 32'd1);
    chk("t_busy18", 32'(cap_busy[18]), 32'd0);
    chk("t_done18", 32'(cap_done[18]), 32'd1);
    chk("t_done_n", 32'(count_done(0, 21)), 32'd1);

    // Word 2 "SOS" looping: measure pulse and gap run lengths
    start1(2, 1'b1, 1'b0);
    capture1(200);
    chk("sos_led0", 32'(cap_led[0]), 32'd0);
    prev = cap_led[1];
    run  = 1;
    seen = 1'b0;
    for (int k = 2; k < 200; k++) begin
      if (cap_led[k] == prev) begin
        run++;
      end else begin
        if (prev) begin
          pl.push_back(run);
          seen = 1'b1;
        end else if (seen) begin
          gl.push_back(run);
        end
        prev = cap_led[k];
        run  = 1;
      end
    end
    chk("sos_npulse", 32'(pl.size()), 32'd13);
    chk("sos_ngap",   32'(gl.size()), 32'd13);
    for (int i = 0; i < 13; i++) begin
      if (i < pl.size()) chk($sformatf("sos_pulse%0d", i), 32'(pl[i]), 32'(exp_p[i]));
      if (i < gl.size()) chk($sformatf("sos_gap%0d", i),   32'(gl[i]), 32'(exp_g[i]));
    end
    chk("sos_done_n", 32'(count_done(0, 199)), 32'd0);
    chk("sos_middash", 32'(cap_led[199]), 32'd1);

    // Abort in the middle of the repeated dash
    bus1.abort = 1'b1;
    @(negedge clk);
    chk("abort_led",  32'(bus1.morse_led), 32'd0);
    chk("abort_busy", 32'(bus1.busy),      32'd0);
    chk("abort_done", 32'(bus1.done),      32'd0);
    bus1.abort = 1'b0;
    capture1(6);
    chk("abort_no_done", 32'(count_done(0, 5)), 32'd0);
    chk("abort_idle",    32'(cap_busy[5]),      32'd0);

    // Asynchronous reset while the dash is on
    start1(1, 1'b0, 1'b0);
    capture1(6);
    chk("rmid_on", 32'(cap_led[5]), 32'd1);
    reset = 1'b0;
    #1;
    chk("rmid_led",  32'(bus1.morse_led), 32'd0);
    chk("rmid_busy", 32'(bus1.busy),      32'd0);
    chk("rmid_done", 32'(bus1.done),      32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Word 3 "A" with set held: restart from symbol 0, re-accept on done
    start1(3, 1'b0, 1'b1);
    capture1(32);
    bus1.set = 1'b0;
    chk("a_led1",   32'(cap_led[1]),  32'd1);
    chk("a_led5",   32'(cap_led[5]),  32'd0);
    chk("a_led10",  32'(cap_led[10]), 32'd1);
    chk("a_led21",  32'(cap_led[21]), 32'd1);
    chk("a_led22",  32'(cap_led[22]), 32'd0);
    chk("a_on_cnt", 32'(count_led(0, 27)), 32'd16);
    chk("a_busy26", 32'(cap_busy[26]), 32'd1);
    chk("a_busy27", 32'(cap_busy[27]), 32'd0);
    chk("a_done27", 32'(cap_done[27]), 32'd1);
    chk("a_done_n", 32'(count_done(0, 26)), 32'd0);
    chk("a_busy28", 32'(cap_busy[28]), 32'd1);
    chk("a_led28",  32'(cap_led[28]), 32'd0);
    chk("a_led29",  32'(cap_led[29]), 32'd1);
    @(negedge clk);
    bus1.abort = 1'b1;
    @(negedge clk);
    bus1.abort = 1'b0;

    // Sweep instance: dash, dot, implied END
    @(negedge clk);
    bus2.data = 16'd0;
    bus2.loop = 1'b0;
    bus2.set  = 1'b1;
    @(posedge clk);
    #1;
    bus2.set = 1'b0;
    capture2(12);
    chk("sw_led0",   32'(cap_led[0]), 32'd0);
    chk("sw_led1",   32'(cap_led[1]), 32'd1);
    chk("sw_led3",   32'(cap_led[3]), 32'd1);
    chk("sw_led4",   32'(cap_led[4]), 32'd0);
    chk("sw_led5",   32'(cap_led[5]), 32'd0);
    chk("sw_led6",   32'(cap_led[6]), 32'd1);
    chk("sw_led7",   32'(cap_led[7]), 32'd0);
    chk("sw_on_cnt", 32'(count_led(0, 11)), 32'd4);
    chk("sw_busy8",  32'(cap_busy[8]), 32'd1);
    chk("sw_busy9",  32'(cap_busy[9]), 32'd0);
    chk("sw_done9",  32'(cap_done[9]), 32'd1);
    chk("sw_done_n", 32'(count_done(0, 11)), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
